// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, the hex glyph table
// (active-high, segment a on bit 0) and a lookup helper.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'h7F;

   localparam seg_t M_A = seg_t'(1) << SEG_A;
   localparam seg_t M_B = seg_t'(1) << SEG_B;
   localparam seg_t M_C = seg_t'(1) << SEG_C;
   localparam seg_t M_D = seg_t'(1) << SEG_D;
   localparam seg_t M_E = seg_t'(1) << SEG_E;
   localparam seg_t M_F = seg_t'(1) << SEG_F;
   localparam seg_t M_G = seg_t'(1) << SEG_G;

   // Entry 15 first: the concatenation fills the highest index first.
   localparam logic [15:0][6:0] SEG_TABLE = {
      M_A |                   M_E | M_F | M_G,   // F
      M_A |             M_D | M_E | M_F | M_G,   // E
            M_B | M_C | M_D | M_E |       M_G,   // d
      M_A |             M_D | M_E | M_F,         // C
                  M_C | M_D | M_E | M_F | M_G,   // b
      M_A | M_B | M_C |       M_E | M_F | M_G,   // A
      M_A | M_B | M_C | M_D |       M_F | M_G,   // 9
      M_A | M_B | M_C | M_D | M_E | M_F | M_G,   // 8
      M_A | M_B | M_C,                           // 7
      M_A |       M_C | M_D | M_E | M_F | M_G,   // 6
      M_A |       M_C | M_D |       M_F | M_G,   // 5
            M_B | M_C |             M_F | M_G,   // 4
      M_A | M_B | M_C | M_D |             M_G,   // 3
      M_A | M_B |       M_D | M_E |       M_G,   // 2
            M_B | M_C,                           // 1
      M_A | M_B | M_C | M_D | M_E | M_F          // 0
   };

   function automatic seg_t hex_to_seg(input logic [3:0] i_hex);
      return SEG_TABLE[i_hex];
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Shared combinational hex-to-segment decoder; output is active-high, the
// caller inverts when registering onto the pins.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_nib,
   output seg_t       o_seg
);

   assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment driver with double-buffered value,
// ghost blanking, leading-zero suppression, per-digit blink and decimal points.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int GHOST_CYC    = 16,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
   input  logic [4*DIGITS-1:0] value_i,
   input  logic [DIGITS-1:0]   dp_i,
   input  logic [DIGITS-1:0]   blink_i,
   input  logic                lz_blank_i,
   output logic [6:0]          seg_o,
   output logic                dp_o,
   output logic [DIGITS-1:0]   an_o,
   output logic                frame_o
);

   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [PRE_W-1:0] GHOST    = PRE_W'(GHOST_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

   logic [PRE_W-1:0]    r_pre;
   logic [IDX_W-1:0]    r_idx;
   logic [BLK_W-1:0]    r_blk_cnt;
   logic                r_phase;

   logic [4*DIGITS-1:0] r_sh_val;
   logic [DIGITS-1:0]   r_sh_dp;
   logic [DIGITS-1:0]   r_sh_blink;
   logic [4*DIGITS-1:0] r_act_val;
   logic [DIGITS-1:0]   r_act_dp;
   logic [DIGITS-1:0]   r_act_blink;

   logic [6:0]          r_seg;
   logic                r_dp;
   logic [DIGITS-1:0]   r_an;
   logic                r_frame;

   logic                w_pre_wrap;
   logic                w_frame_wrap;
   logic [3:0]          w_nib;
   seg_t                w_seg;
   logic [DIGITS-1:0]   w_zero_up;
   logic                w_suppress;
   logic                w_an_on;

   assign w_pre_wrap   = (r_pre == PRE_LAST);
   assign w_frame_wrap = w_pre_wrap && (r_idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
         r_idx <= '0;
      end else if (w_pre_wrap) begin
         r_pre <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   // A load landing on the frame boundary goes straight to the active copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_val    <= '0;
         r_sh_dp     <= '0;
         r_sh_blink  <= '0;
         r_act_val   <= '0;
         r_act_dp    <= '0;
         r_act_blink <= '0;
      end else begin
         if (load_i) begin
            r_sh_val   <= value_i;
            r_sh_dp    <= dp_i;
            r_sh_blink <= blink_i;
         end
         if (w_frame_wrap) begin
            r_act_val   <= load_i ? value_i : r_sh_val;
            r_act_dp    <= load_i ? dp_i    : r_sh_dp;
            r_act_blink <= load_i ? blink_i : r_sh_blink;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk_cnt <= '0;
         r_phase   <= 1'b0;
      end else if (w_frame_wrap) begin
         if (r_blk_cnt == BLK_LAST) begin
            r_blk_cnt <= '0;
            r_phase   <= ~r_phase;
         end else begin
            r_blk_cnt <= r_blk_cnt + 1'b1;
         end
      end
   end

   // w_zero_up[k]: digit k and every digit above it are zero.
   always_comb begin
      logic v_run;
      v_run     = 1'b1;
      w_zero_up = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         v_run        = v_run && (r_act_val[4*k +: 4] == 4'h0);
         w_zero_up[k] = v_run;
      end
   end

   assign w_nib      = r_act_val[{r_idx, 2'b00} +: 4];
   assign w_suppress = lz_blank_i && (r_idx != '0) && w_zero_up[r_idx];
   assign w_an_on    = (r_pre >= GHOST) && !(r_phase && r_act_blink[r_idx]);

   seg7_hex_decode u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg   <= SEG_OFF;
         r_dp    <= 1'b1;
         r_an    <= '1;
         r_frame <= 1'b0;
      end else begin
         r_seg   <= w_suppress ? SEG_OFF : ~w_seg;
         r_dp    <= ~r_act_dp[r_idx];
         r_an    <= w_an_on ? ~(DIGITS'(1) << r_idx) : '1;
         r_frame <= (r_pre == '0) && (r_idx == '0);
      end
   end

   assign seg_o   = r_seg;
   assign dp_o    = r_dp;
   assign an_o    = r_an;
   assign frame_o = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues the expected glyph of
// every digit it expects to light; a monitor pops one entry per anode turn-on.
module tb_seg7_scan_driver;

   localparam int DIGITS = 4;

   localparam logic [6:0] S0  = 7'h40;
   localparam logic [6:0] S1  = 7'h79;
   localparam logic [6:0] S2  = 7'h24;
   localparam logic [6:0] S3  = 7'h30;
   localparam logic [6:0] S4  = 7'h19;
   localparam logic [6:0] S5  = 7'h12;
   localparam logic [6:0] S8  = 7'h00;
   localparam logic [6:0] SA  = 7'h08;
   localparam logic [6:0] SF  = 7'h0E;
   localparam logic [6:0] OFF = 7'h7F;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        load_i;
   logic [15:0] value_i;
   logic [3:0]  dp_i;
   logic [3:0]  blink_i;
   logic        lz_blank_i;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic [3:0]  an_o;
   logic        frame_o;

   exp_t q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   seg7_scan_driver #(
      .DIGITS       (DIGITS),
      .SCAN_DIV     (8),
      .GHOST_CYC    (2),
      .BLINK_FRAMES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load_i),
      .value_i    (value_i),
      .dp_i       (dp_i),
      .blink_i    (blink_i),
      .lz_blank_i (lz_blank_i),
      .seg_o      (seg_o),
      .dp_o       (dp_o),
      .an_o       (an_o),
      .frame_o    (frame_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " seg_o"},   32'(seg_o),   32'h7F);
      check({tag, " an_o"},    32'(an_o),    32'hF);
      check({tag, " dp_o"},    32'(dp_o),    32'h1);
      check({tag, " frame_o"}, 32'(frame_o), 32'h0);
   endtask

   task automatic push_frame(input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] dpm, input logic [3:0] hide);
      logic [6:0] s [4];
      exp_t e;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      for (int k = 0; k < 4; k++) begin
         if (!hide[k]) begin
            e.an  = ~(4'b0001 << k);
            e.seg = s[k];
            e.dp  = ~dpm[k];
            q.push_back(e);
         end
      end
   endtask

   task automatic next_frame();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_o && n < 40);
      check("frame_o seen", 32'(frame_o), 32'h1);
   endtask

   task automatic load_vec(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value_i = v;
      dp_i    = d;
      blink_i = b;
      load_i  = 1'b1;
      @(negedge clk);
      load_i  = 1'b0;
   endtask

   // Monitor: glyph check on each anode turn-on, width check on turn-off,
   // and frame_o period check.
   logic [3:0] prev_an   = 4'hF;
   int         lo_cnt    = 0;
   bit         tracking  = 1'b0;
   int         cyc       = 0;
   int         last_fr   = -1;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_an  = 4'hF;
         lo_cnt   = 0;
         tracking = 1'b0;
         last_fr  = -1;
      end else begin
         if (frame_o) begin
            if (last_fr >= 0) check("frame_o period", 32'(cyc - last_fr), 32'd32);
            last_fr = cyc;
         end
         if (an_o != 4'hF && prev_an == 4'hF) begin
            if (q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected digit: an_o=%0h seg_o=%0h with nothing expected", an_o, seg_o);
            end else begin
               exp_t e;
               e = q.pop_front();
               check($sformatf("an_o (exp %0h)", e.an), 32'(an_o), 32'(e.an));
               check($sformatf("seg_o on an %0h", e.an), 32'(seg_o), 32'(e.seg));
               check($sformatf("dp_o on an %0h", e.an), 32'(dp_o), 32'(e.dp));
            end
            tracking = 1'b1;
            lo_cnt   = 1;
         end else if (an_o != 4'hF) begin
            lo_cnt++;
         end else if (prev_an != 4'hF && tracking) begin
            check($sformatf("anode %0h low width", prev_an), 32'(lo_cnt), 32'd6);
            tracking = 1'b0;
         end
         prev_an = an_o;
      end
   end

   initial begin
      rst_n      = 1'b1;
      load_i     = 1'b0;
      value_i    = '0;
      dp_i       = '0;
      blink_i    = '0;
      lz_blank_i = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset("initial reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      next_frame();
      push_frame(S0, S0, S0, S0, 4'b0000, 4'b0000);
      load_vec(16'h1A2F, 4'b0100, 4'b0000);

      next_frame();
      push_frame(S1, SA, S2, SF, 4'b0100, 4'b0000);
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("mid-slot reset");
      q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      next_frame();
      push_frame(S0, S0, S0, S0, 4'b0000, 4'b0000);
      load_vec(16'h8888, 4'b0000, 4'b0000);

      next_frame();
      push_frame(S8, S8, S8, S8, 4'b0000, 4'b0000);
      repeat (10) @(negedge clk);
      load_vec(16'h1234, 4'b0000, 4'b0000);

      next_frame();
      push_frame(S1, S2, S3, S4, 4'b0000, 4'b0000);
      repeat (30) @(negedge clk);
      load_vec(16'h4321, 4'b0000, 4'b0000);

      next_frame();
      push_frame(S4, S3, S2, S1, 4'b0000, 4'b0000);
      lz_blank_i = 1'b1;
      load_vec(16'h0050, 4'b1000, 4'b0000);

      next_frame();
      push_frame(OFF, OFF, S5, S0, 4'b1000, 4'b0000);
      load_vec(16'h0000, 4'b0000, 4'b0000);

      next_frame();
      push_frame(OFF, OFF, OFF, S0, 4'b0000, 4'b0000);
      load_vec(16'h1A2F, 4'b0000, 4'b0001);

      next_frame();
      push_frame(S1, SA, S2, SF, 4'b0000, 4'b0001);
      next_frame();
      push_frame(S1, SA, S2, SF, 4'b0000, 4'b0001);
      next_frame();
      push_frame(S1, SA, S2, SF, 4'b0000, 4'b0000);
      next_frame();
      push_frame(S1, SA, S2, SF, 4'b0000, 4'b0000);
      next_frame();
      push_frame(S1, SA, S2, SF, 4'b0000, 4'b0001);

      next_frame();
      @(negedge clk);
      check("expected digits left unshown", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
